zig_fifo_sched: RTL and testbench
=================================

ZIG_FIFO_SCHED -- requirements
Module: zig_fifo_sched

Interface
REQ-001 Parameter FIFO_SIZE, no default (-1, must be overridden), depth of the sequenced MCU FIFO in MCUs.
REQ-002 Parameter MCU_SIZE, no default (-1, must be overridden), block edge; N = MCU_SIZE*MCU_SIZE coefficients per component.
REQ-003 clk  in  1  clock; all logic rising-edge.
REQ-004 n_rst  in  1  reset, synchronous, active-low.
REQ-005 i_in_valid  in  1  producer offers one complete Y/U/V MCU.
REQ-006 o_in_ready  out  1  = !i_fifo_full; write occurs when i_in_valid & o_in_ready.
REQ-007 o_fifo_we  out  1  combinational i_in_valid & !i_fifo_full.
REQ-008 o_fifo_re  out  1  single-cycle FIFO pop request.
REQ-009 o_fifo_wait  out  1  freezes the FIFO's output valid flag.
REQ-010 i_fifo_empty, i_fifo_full  in  1 each  FIFO status.
REQ-011 i_fifo_valid  in  1  FIFO output valid, one cycle after an accepted re.
REQ-012 i_fifo_last  in  1  last-MCU-of-frame flag carried with the popped MCU.
REQ-013 i_out_ready  in  1  serial consumer accepts current coefficient.
REQ-014 o_out_valid  out  1  coefficient select valid.
REQ-015 o_comp  out  2  component select: 0=Y, 1=U, 2=V; 3 never driven.
REQ-016 o_coef_idx  out  $clog2(N)  coefficient index 0..N-1.
REQ-017 o_coef_last  out  1  high on index N-1 of V of an MCU whose i_fifo_last was set.
REQ-018 o_frame_done  out  1  one-cycle pulse after frame's final coefficient accepted.
REQ-019 o_busy  out  1  high in any state except IDLE.

Function
REQ-020 FSM states IDLE, FETCH, LOAD, STREAM, DONE; one-hot or binary at implementer's choice.
REQ-021 IDLE: if !i_fifo_empty, go to FETCH; else stay.
REQ-022 FETCH: assert o_fifo_re for exactly one cycle (only if !i_fifo_empty), go to LOAD.
REQ-023 LOAD: wait for i_fifo_valid; on it, latch i_fifo_last into last_q, clear comp/idx to 0, go to STREAM.
REQ-024 STREAM: o_out_valid=1; handshake = o_out_valid & i_out_ready; on handshake idx increments; idx N-1 wraps to 0 and comp increments Y->U->V.
REQ-025 Handshake on (comp=2, idx=N-1): go to DONE if last_q, else to FETCH if !i_fifo_empty, else IDLE.
REQ-026 DONE: o_frame_done=1 one cycle, clear last_q, go to IDLE.
REQ-027 o_fifo_wait=1 in LOAD-after-valid and STREAM, so FIFO data and valid stay stable while coefficients are selected; 0 otherwise.
REQ-028 o_fifo_re never asserted outside FETCH; never two pops per MCU.
REQ-029 o_comp/o_coef_idx hold value while o_out_valid & !i_out_ready.
REQ-030 Latency: FETCH entry to first o_out_valid = 2 cycles; back-to-back MCUs have 2 idle cycles (FETCH, LOAD) between final V and next Y coefficient.
REQ-031 Writes independent of FSM; simultaneous write and pop in FETCH both take effect.
REQ-032 i_in_valid while i_fifo_full: no write, o_in_ready=0, producer must hold.
REQ-033 i_fifo_empty rising in FETCH (should not occur): no re, return to IDLE.

Reset
REQ-034 On !n_rst: state IDLE, comp=0, idx=0, last_q=0; o_fifo_re, o_fifo_wait, o_out_valid, o_coef_last, o_frame_done, o_busy all 0.
REQ-035 Reset mid-STREAM aborts MCU immediately; no o_frame_done; FIFO reset concurrently by shared n_rst.

Structure
REQ-036 Shared package holds the state enum type and component-select enum (Y=0,U=1,V=2).
REQ-037 No sub-module; instantiated beside the MCU FIFO wrapper in the encoder top.

Verification (MCU_SIZE=8, FIFO_SIZE=4, N=64)
REQ-038 One MCU, i_out_ready=1 -> o_fifo_re one pulse; 192 consecutive o_out_valid cycles, comp 0/1/2 with idx 0..63 each; no o_frame_done.
REQ-039 Three MCUs, third last=1 -> exactly 3 re pulses; o_coef_last once at comp=2 idx=63 of MCU 3; o_frame_done one cycle later.
REQ-040 i_out_ready low 5 cycles at comp=1 idx=17 -> comp/idx held, o_fifo_wait stays 1, resumes at idx 18.
REQ-041 Producer pushes 5 MCUs with consumer stalled -> o_in_ready=0 after 4 writes; 5th write lands only after first pop.
REQ-042 n_rst low at comp=2 idx=30 -> next cycle all outputs 0, state IDLE; post-reset MCU streams from comp=0 idx=0.

Source files
------------

// File: rtl/zig_fifo_sched_pkg.sv
// Shared types for the zig-zag MCU scheduler: FSM state and component select.
package zig_fifo_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_STREAM = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        COMP_Y = 2'd0,
        COMP_U = 2'd1,
        COMP_V = 2'd2
    } comp_t;

endpackage

// File: rtl/zig_fifo_sched.sv
// Pops one Y/U/V MCU at a time from the MCU FIFO and walks its coefficients
// (Y then U then V, index 0..N-1) towards a serial consumer.
module zig_fifo_sched
    import zig_fifo_sched_pkg::*;
#(
    parameter int FIFO_SIZE = -1,
    parameter int MCU_SIZE  = -1,
    localparam int unsigned N     = 32'(MCU_SIZE * MCU_SIZE),
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic             o_fifo_we,
    output logic             o_fifo_re,
    output logic             o_fifo_wait,
    input  logic             i_fifo_empty,
    input  logic             i_fifo_full,
    input  logic             i_fifo_valid,
    input  logic             i_fifo_last,
    input  logic             i_out_ready,
    output logic             o_out_valid,
    output logic [1:0]       o_comp,
    output logic [IDX_W-1:0] o_coef_idx,
    output logic             o_coef_last,
    output logic             o_frame_done,
    output logic             o_busy
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] IDX_PEN  = IDX_W'(N - 2);

    state_t           state_q;
    comp_t            comp_q;
    logic [IDX_W-1:0] idx_q;
    logic             last_q;
    logic             out_valid_q;
    logic             coef_last_q;
    logic             frame_done_q;
    logic             busy_q;

    // FIFO-side strobes follow the FSM state within the cycle so an empty
    // FIFO is never popped and the output valid is frozen as soon as it lands.
    assign o_in_ready  = !i_fifo_full;
    assign o_fifo_we   = i_in_valid && !i_fifo_full;
    assign o_fifo_re   = (state_q == ST_FETCH) && !i_fifo_empty;
    assign o_fifo_wait = (state_q == ST_STREAM) || ((state_q == ST_LOAD) && i_fifo_valid);

    assign o_out_valid  = out_valid_q;
    assign o_comp       = comp_q;
    assign o_coef_idx   = idx_q;
    assign o_coef_last  = coef_last_q;
    assign o_frame_done = frame_done_q;
    assign o_busy       = busy_q;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            comp_q       <= COMP_Y;
            idx_q        <= '0;
            last_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            coef_last_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (!i_fifo_empty) begin
                        state_q <= ST_FETCH;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (!i_fifo_empty) begin
                        state_q <= ST_LOAD;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (i_fifo_valid) begin
                        last_q      <= i_fifo_last;
                        comp_q      <= COMP_Y;
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        coef_last_q <= 1'b0;
                        state_q     <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (i_out_ready) begin
                        // Flag is registered one step early so it aligns with V[N-1].
                        coef_last_q <= last_q && (comp_q == COMP_V) && (idx_q == IDX_PEN);
                        if (idx_q != IDX_LAST) begin
                            idx_q <= idx_q + IDX_W'(1);
                        end else begin
                            idx_q <= '0;
                            if (comp_q != COMP_V) begin
                                comp_q <= (comp_q == COMP_Y) ? COMP_U : COMP_V;
                            end else begin
                                out_valid_q <= 1'b0;
                                if (last_q) begin
                                    state_q      <= ST_DONE;
                                    frame_done_q <= 1'b1;
                                end else if (!i_fifo_empty) begin
                                    state_q <= ST_FETCH;
                                end else begin
                                    state_q <= ST_IDLE;
                                    busy_q  <= 1'b0;
                                end
                            end
                        end
                    end
                end
                ST_DONE: begin
                    last_q  <= 1'b0;
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // FIFO_SIZE sizes the companion FIFO; only its legality matters here.
    param_legal: assert property (@(posedge clk) (FIFO_SIZE > 0) && (MCU_SIZE > 1));

endmodule

// File: tb/tb_zig_fifo_sched.sv
// Self-checking bench for zig_fifo_sched with a behavioural MCU FIFO and a
// per-MCU coefficient scoreboard.
module tb_zig_fifo_sched;

    localparam int DEPTH = 4;
    localparam int MSZ   = 8;
    localparam int NC    = MSZ * MSZ;
    localparam int NMCU  = 3 * NC;
    localparam int BUDGET = 4000;

    logic       clk, n_rst;
    logic       i_in_valid, i_fifo_empty, i_fifo_full, i_fifo_valid, i_fifo_last, i_out_ready;
    logic       o_in_ready, o_fifo_we, o_fifo_re, o_fifo_wait, o_out_valid;
    logic       o_coef_last, o_frame_done, o_busy;
    logic [1:0] o_comp;
    logic [5:0] o_coef_idx;

    zig_fifo_sched #(.FIFO_SIZE(DEPTH), .MCU_SIZE(MSZ)) dut (
        .clk(clk), .n_rst(n_rst),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .o_fifo_we(o_fifo_we), .o_fifo_re(o_fifo_re), .o_fifo_wait(o_fifo_wait),
        .i_fifo_empty(i_fifo_empty), .i_fifo_full(i_fifo_full),
        .i_fifo_valid(i_fifo_valid), .i_fifo_last(i_fifo_last),
        .i_out_ready(i_out_ready), .o_out_valid(o_out_valid),
        .o_comp(o_comp), .o_coef_idx(o_coef_idx), .o_coef_last(o_coef_last),
        .o_frame_done(o_frame_done), .o_busy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc;

    // environment: producer queue, FIFO contents and FIFO output register
    bit pend[$];
    bit fq[$];
    bit cur_valid, cur_last, prod_hold, prod_rand;
    int ready_mode;
    bit stall_en, stall_used;
    int stall_cnt;

    // scoreboard
    bit loading, active, cur_mcu_last, pop_last, exp_done, exp_re;
    int p, re_cyc, we_cyc, mcus_done;
    int n_re, n_we, n_hs, n_valid, n_clast, n_done;
    int re_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic apply();
        i_fifo_valid = cur_valid;
        i_fifo_last  = cur_last;
        i_fifo_empty = (fq.size() == 0);
        i_fifo_full  = (fq.size() >= DEPTH);
        if (prod_hold) i_in_valid = 1'b1;
        else i_in_valid = (pend.size() > 0) && (!prod_rand || ($urandom_range(0, 1) == 1));
        if (stall_cnt > 0) begin
            i_out_ready = 1'b0;
            stall_cnt--;
        end else if (stall_en && !stall_used && o_out_valid && o_comp == 2'd1 && o_coef_idx == 6'd17) begin
            stall_used  = 1'b1;
            stall_cnt   = 4;
            i_out_ready = 1'b0;
        end else begin
            case (ready_mode)
                1:       i_out_ready = ($urandom_range(0, 1) == 1);
                2:       i_out_ready = 1'b0;
                default: i_out_ready = 1'b1;
            endcase
        end
    endtask

    // One clock: sample at the falling edge, update the model, drive after the rising edge.
    task automatic step();
        bit hs, nv, nl;
        int cnt0;
        @(negedge clk);
        cyc++;
        cnt0 = fq.size();
        chk("in_ready", o_in_ready, cnt0 < DEPTH);
        chk("fifo_we", o_fifo_we, i_in_valid && (cnt0 < DEPTH));
        chk("frame_done", o_frame_done, exp_done);
        exp_done = 1'b0;
        if (exp_re) chk("re_back_to_back", o_fifo_re, 1);
        exp_re = 1'b0;
        if (o_out_valid || (loading && i_fifo_valid)) chk("fifo_wait_hi", o_fifo_wait, 1);
        else if (!active && !loading) chk("fifo_wait_lo", o_fifo_wait, 0);

        if (o_out_valid) begin
            n_valid++;
            if (loading) begin
                chk("first_valid_latency", cyc - re_cyc, 2);
                loading = 1'b0;
                active = 1'b1;
                p = 0;
                cur_mcu_last = pop_last;
            end else if (!active) begin
                chk("spurious_valid", o_out_valid, 0);
            end
        end else if (active) begin
            chk("valid_dropped", o_out_valid, 1);
        end

        hs = o_out_valid && i_out_ready && active;
        if (active && o_out_valid) begin
            chk("comp", o_comp, p / NC);
            chk("coef_idx", o_coef_idx, p % NC);
            chk("coef_last", o_coef_last, cur_mcu_last && (p == NMCU - 1));
        end else begin
            chk("coef_last_idle", o_coef_last, 0);
        end
        if (hs) begin
            n_hs++;
            if (o_coef_last) n_clast++;
            p++;
            if (p == NMCU) begin
                active = 1'b0;
                mcus_done++;
                if (cur_mcu_last) exp_done = 1'b1;
                else if (cnt0 > 0) exp_re = 1'b1;
            end
        end
        if (o_frame_done) n_done++;

        nl = cur_last;
        nv = o_fifo_wait ? cur_valid : 1'b0;
        if (o_fifo_re) begin
            n_re++;
            re_q.push_back(cyc);
            chk("re_when_empty", o_fifo_re, cnt0 > 0);
            chk("re_per_mcu", o_fifo_re, !(active || loading));
            loading = 1'b1;
            re_cyc = cyc;
            if (fq.size() > 0) pop_last = fq.pop_front();
            nv = 1'b1;
            nl = pop_last;
        end
        prod_hold = i_in_valid && !o_fifo_we;
        if (o_fifo_we) begin
            n_we++;
            we_cyc = cyc;
            if (pend.size() > 0) fq.push_back(pend.pop_front());
        end
        @(posedge clk);
        #1;
        cur_valid = nv;
        cur_last  = nl;
        apply();
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        i_in_valid = 1'b0;
        i_out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_fifo_re", o_fifo_re, 0);
        chk("rst_fifo_wait", o_fifo_wait, 0);
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_coef_last", o_coef_last, 0);
        chk("rst_frame_done", o_frame_done, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_comp", o_comp, 0);
        chk("rst_coef_idx", o_coef_idx, 0);
        pend.delete(); fq.delete(); re_q.delete();
        cur_valid = 0; cur_last = 0; prod_hold = 0; prod_rand = 0;
        ready_mode = 0; stall_en = 0; stall_used = 0; stall_cnt = 0;
        loading = 0; active = 0; exp_done = 0; exp_re = 0; pop_last = 0; cur_mcu_last = 0;
        p = 0; re_cyc = 0; we_cyc = 0; mcus_done = 0;
        n_re = 0; n_we = 0; n_hs = 0; n_valid = 0; n_clast = 0; n_done = 0;
        n_rst = 1'b1;
        apply();
    endtask

    task automatic run_until(input int target);
        int k = 0;
        while (!(mcus_done >= target && !o_busy && pend.size() == 0) && k < BUDGET) begin
            step();
            k++;
        end
        chk("drain_timeout", k < BUDGET, 1);
        step();
    endtask

    typedef struct {
        int       n;
        bit [3:0] lasts;
        bit       stall;
        int       rmode;
        int       exp_re;
        int       exp_hs;
        int       exp_valid;
        int       exp_clast;
        int       exp_done;
    } vec_t;

    vec_t v[5];

    initial begin
        cyc = 0;
        n_rst = 1'b0;
        i_in_valid = 0; i_fifo_empty = 1; i_fifo_full = 0;
        i_fifo_valid = 0; i_fifo_last = 0; i_out_ready = 1;

        v[0] = '{1, 4'b0000, 1'b0, 0, 1, 192, 192, 0, 0};
        v[1] = '{3, 4'b0100, 1'b0, 0, 3, 576, 576, 1, 1};
        v[2] = '{1, 4'b0001, 1'b1, 0, 1, 192, 197, 1, 1};
        v[3] = '{2, 4'b0011, 1'b0, 0, 2, 384, 384, 2, 2};
        v[4] = '{4, 4'b1010, 1'b0, 1, 4, 768, -1,  2, 2};

        for (int t = 0; t < 5; t++) begin
            do_reset();
            ready_mode = v[t].rmode;
            stall_en = v[t].stall;
            for (int m = 0; m < v[t].n; m++) pend.push_back(v[t].lasts[m]);
            run_until(v[t].n);
            chk("vec_re_pulses", n_re, v[t].exp_re);
            chk("vec_handshakes", n_hs, v[t].exp_hs);
            if (v[t].exp_valid >= 0) chk("vec_valid_cycles", n_valid, v[t].exp_valid);
            chk("vec_coef_last", n_clast, v[t].exp_clast);
            chk("vec_frame_done", n_done, v[t].exp_done);
        end

        // randomized producer and consumer timing
        for (int r = 0; r < 3; r++) begin
            int n;
            bit [3:0] lasts;
            n = $urandom_range(2, 4);
            lasts = 4'($urandom_range(0, 15));
            do_reset();
            ready_mode = 1;
            prod_rand = 1;
            for (int m = 0; m < n; m++) pend.push_back(lasts[m]);
            lasts = lasts & 4'((1 << n) - 1);
            run_until(n);
            chk("rnd_re_pulses", n_re, n);
            chk("rnd_handshakes", n_hs, n * NMCU);
            chk("rnd_coef_last", n_clast, $countones(lasts));
            chk("rnd_frame_done", n_done, $countones(lasts));
        end

        // full FIFO back-pressures the producer while the consumer is stalled
        begin
            int k = 0;
            do_reset();
            ready_mode = 2;
            pend.push_back(1'b0);
            while (!active && k < 100) begin step(); k++; end
            chk("bp_stream_start", active, 1);
            for (int m = 0; m < 5; m++) pend.push_back(m == 4);
            for (int c = 0; c < 12; c++) step();
            chk("bp_writes_when_full", n_we, 5);
            chk("bp_in_ready_low", o_in_ready, 0);
            chk("bp_fifo_level", fq.size(), DEPTH);
            ready_mode = 0;
            run_until(6);
            chk("bp_re_pulses", n_re, 6);
            chk("bp_fifth_after_pop", (re_q.size() > 1) && (we_cyc > re_q[1]), 1);
            chk("bp_frame_done", n_done, 1);
        end

        // reset in the middle of V aborts the MCU; the next one starts clean
        begin
            int k = 0;
            do_reset();
            pend.push_back(1'b1);
            while (!(o_out_valid && o_comp == 2'd2 && o_coef_idx == 6'd30) && k < 1000) begin
                step();
                k++;
            end
            chk("mid_reset_reached", o_coef_idx, 30);
            do_reset();
            for (int c = 0; c < 3; c++) step();
            chk("mid_reset_no_done", n_done, 0);
            chk("mid_reset_idle", o_busy, 0);
            pend.push_back(1'b0);
            run_until(1);
            chk("post_reset_re", n_re, 1);
            chk("post_reset_hs", n_hs, NMCU);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
